// File: rtl/fgen_pkg.sv
// Shared constants, FSM encoding and small helpers for the waveform generator front end.
package fgen_pkg;

  localparam int FW = 24;
  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

  localparam int unsigned DEBOUNCE_MS = 20;
  localparam int unsigned HOLD_MS = 500;
  localparam int unsigned REPEAT_MS = 100;

  localparam int unsigned DEBOUNCE_CYCLES_50M = DEBOUNCE_MS * CYCLES_PER_MS;
  localparam int unsigned HOLD_CYCLES_50M = HOLD_MS * CYCLES_PER_MS;
  localparam int unsigned REPEAT_CYCLES_50M = REPEAT_MS * CYCLES_PER_MS;

  typedef logic [2:0] fsm_state_t;
  localparam fsm_state_t IDLE = 3'd0;
  localparam fsm_state_t STEP_UP = 3'd1;
  localparam fsm_state_t STEP_DN = 3'd2;
  localparam fsm_state_t HOLD = 3'd3;
  localparam fsm_state_t REPEAT = 3'd4;
  localparam fsm_state_t LOCKED = 3'd5;

  // Button pair is always ordered {plus, minus}.
  localparam logic [1:0] PAIR_NONE = 2'b00;
  localparam logic [1:0] PAIR_PLUS = 2'b10;
  localparam logic [1:0] PAIR_MINUS = 2'b01;
  localparam logic [1:0] PAIR_BOTH = 2'b11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_count);
    if (max_count < 1) return 1;
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser and stability counter for the {plus, minus} button pair.
// pair_valid rises the first time any pair has been accepted since reset.
module btn_sync_debounce
  import fgen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int unsigned CW = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw,
  output logic [1:0] pair,
  output logic       pair_valid
);

  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // cnt holds the number of consecutive identical samples, so a change restarts it at 1.
  always_comb begin
    cnt_next = cnt;
    if (sync2 != cand) cnt_next = ONE;
    else if (cnt < DEB_C) cnt_next = cnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      cand <= 2'b00;
      cnt <= '0;
      pair <= PAIR_NONE;
      pair_valid <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cand <= sync2;
      cnt <= cnt_next;
      if (cnt_next >= DEB_C) begin
        pair <= sync2;
        pair_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_step_ctrl.sv
// Push-button front end: debounced single step plus auto-repeat on a saturating
// frequency tuning word consumed by the phase accumulator.
module freq_step_ctrl
  import fgen_pkg::*;
#(
  parameter int unsigned FW = fgen_pkg::FW,
  parameter logic [FW-1:0] STEP = FW'(1024),
  parameter logic [FW-1:0] FW_MIN = FW'(1024),
  parameter logic [FW-1:0] FW_MAX = FW'(8388608),
  parameter logic [FW-1:0] FW_DEFAULT = FW'(65536),
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_50M,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_50M
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          Bt_Plus,
  input  logic          Bt_Minus,
  output logic [FW-1:0] freq_word,
  output logic          freq_update,
  output logic          at_min,
  output logic          at_max
);

  if (FW_MIN > FW_DEFAULT || FW_DEFAULT > FW_MAX || STEP == '0) begin : g_param_check
    $error("freq_step_ctrl: need FW_MIN <= FW_DEFAULT <= FW_MAX and STEP >= 1");
  end

  localparam int unsigned CW = cnt_width(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0] pair;
  logic pair_valid;
  fsm_state_t state;
  fsm_state_t state_next;
  logic armed;
  logic dir_up;
  logic [1:0] dir_pair;
  logic [CW-1:0] timer;
  logic step_en;
  logic load_hold;
  logic load_repeat;
  logic [FW:0] sum_up;
  logic [FW:0] dec_floor;
  logic [FW-1:0] inc_word;
  logic [FW-1:0] dec_word;
  logic [FW-1:0] new_word;
  logic changed;

  btn_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CW(CW)
  ) u_debounce (
    .clk(sysclk),
    .reset(reset),
    .raw({Bt_Plus, Bt_Minus}),
    .pair(pair),
    .pair_valid(pair_valid)
  );

  assign dir_pair = dir_up ? PAIR_PLUS : PAIR_MINUS;

  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (armed) begin
          case (pair)
            PAIR_PLUS: state_next = STEP_UP;
            PAIR_MINUS: state_next = STEP_DN;
            PAIR_BOTH: state_next = LOCKED;
            default: state_next = IDLE;
          endcase
        end
      end
      STEP_UP, STEP_DN: state_next = HOLD;
      HOLD, REPEAT: begin
        // Any change away from the held button wins over a step due this cycle.
        if (pair != dir_pair) state_next = (pair == PAIR_BOTH) ? LOCKED : IDLE;
        else if (timer == '0) state_next = REPEAT;
      end
      LOCKED: if (pair == PAIR_NONE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    step_en = 1'b0;
    load_hold = 1'b0;
    load_repeat = 1'b0;
    case (state)
      STEP_UP, STEP_DN: begin
        step_en = 1'b1;
        load_hold = 1'b1;
      end
      HOLD, REPEAT: begin
        if (pair == dir_pair && timer == '0) begin
          step_en = 1'b1;
          load_repeat = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // armed stays low after reset until a released pair has really been accepted,
  // so a button still held through reset cannot start a step.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      armed <= 1'b0;
      dir_up <= 1'b0;
      timer <= '0;
    end else begin
      armed <= armed | (pair_valid & (pair == PAIR_NONE));
      if (state_next == STEP_UP) dir_up <= 1'b1;
      else if (state_next == STEP_DN) dir_up <= 1'b0;
      if (load_hold) timer <= HOLD_C;
      else if (load_repeat) timer <= REPEAT_C;
      else if (timer != '0) timer <= timer - ONE;
    end
  end

  always_comb begin
    sum_up = {1'b0, freq_word} + {1'b0, STEP};
    dec_floor = {1'b0, FW_MIN} + {1'b0, STEP};
    inc_word = (sum_up > {1'b0, FW_MAX}) ? FW_MAX : sum_up[FW-1:0];
    dec_word = ({1'b0, freq_word} < dec_floor) ? FW_MIN : (freq_word - STEP);
    new_word = dir_up ? inc_word : dec_word;
    changed = step_en && (new_word != freq_word);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      freq_word <= FW_DEFAULT;
      freq_update <= 1'b0;
      at_min <= (FW_DEFAULT == FW_MIN);
      at_max <= (FW_DEFAULT == FW_MAX);
    end else begin
      freq_update <= changed;
      if (changed) begin
        freq_word <= new_word;
        at_min <= (new_word == FW_MIN);
        at_max <= (new_word == FW_MAX);
      end
    end
  end

endmodule

// File: doc/freq_step_ctrl.md
Name: freq_step_ctrl

Overview:
- Upstream control stage for the waveform generator top level (`Main`).
- Conditions the raw `Bt_Plus` / `Bt_Minus` push-buttons: synchronise, debounce, single step, then auto-repeat while held.
- Maintains the saturating frequency tuning word that the phase accumulator and waveform stages consume.
- Replaces direct button handling inside `Main`; `Main` instantiates it and wires `freq_word` to the accumulator increment.

Parameters:
- FW, 24, width of the frequency tuning word.
- STEP, 24'd1024, amount added or subtracted per step.
- FW_MIN, 24'd1024, lower saturation bound (inclusive).
- FW_MAX, 24'd8388608, upper saturation bound (inclusive).
- FW_DEFAULT, 24'd65536, value loaded at reset.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz).
- HOLD_CYCLES, 25000000, cycles a press must be held after the first step before auto-repeat starts.
- REPEAT_CYCLES, 5000000, cycles between auto-repeat steps.

Ports:
- sysclk  in  1  system clock (50 MHz); the only clock.
- reset  in  1  synchronous, active-high reset.
- Bt_Plus  in  1  raw, asynchronous, bouncing increment button.
- Bt_Minus  in  1  raw, asynchronous, bouncing decrement button.
- freq_word  out  FW  current tuning word; registered.
- freq_update  out  1  one-cycle pulse in the cycle `freq_word` takes a new value.
- at_min  out  1  high while `freq_word == FW_MIN`; registered.
- at_max  out  1  high while `freq_word == FW_MAX`; registered.

Behaviour:
- Reset values:
  - `freq_word = FW_DEFAULT`, `freq_update = 0`.
  - `at_min` / `at_max` are evaluated against `FW_DEFAULT`.
  - FSM = IDLE, all counters = 0, synchroniser flops = 0.
  - Reset mid-press aborts the current press; the FSM re-arms only after both buttons read released.
- Synchroniser: each button passes through a 2-flop synchroniser. All logic uses the synchronised copies `p` and `m`; this adds 2 cycles of latency.
- Debounce counter:
  - Shared by all states; compares the current `{p,m}` pair with the candidate pair.
  - Any change in `{p,m}` clears the counter.
  - A pair is accepted after DEBOUNCE_CYCLES consecutive identical samples.
- FSM states and transitions:
  - IDLE: waits until the accepted pair is not 00.
    - 10 → STEP_UP.
    - 01 → STEP_DN.
    - 11 → LOCKED.
  - STEP_UP / STEP_DN: last exactly one cycle.
    - Apply the step, pulse `freq_update`, load the hold counter, go to HOLD.
  - HOLD: counts HOLD_CYCLES.
    - If the accepted pair returns to 00 → IDLE.
    - If the accepted pair becomes 11 → LOCKED.
    - On expiry → step again in the same direction, then REPEAT.
  - REPEAT: steps every REPEAT_CYCLES while the same single button stays accepted.
    - Accepted 00 → IDLE.
    - Accepted 11 → LOCKED.
  - LOCKED: reached when both buttons are pressed.
    - No steps occur in this state.
    - Exits to IDLE only when the accepted pair is 00. Releasing one button while the other is held does not start a step.
- Arithmetic:
  - Increment: compute at FW+1 bits; if `freq_word + STEP > FW_MAX`, load FW_MAX.
  - Decrement: if `freq_word < FW_MIN + STEP`, load FW_MIN.
  - `freq_update` pulses only if the new value differs from the old. A step attempted while saturated gives no pulse, but the FSM timing is unchanged.
- Latency: from the raw press edge, with a clean input, `freq_word` changes at cycle 2 + DEBOUNCE_CYCLES + 1.
- Parameter constraints:
  - Legal ranges: FW_MIN ≤ FW_DEFAULT ≤ FW_MAX, and STEP ≥ 1.
  - Illegal parameters are an elaboration error, raised by a generate-time check.
- Counter widths are sized with `$clog2` of the largest cycle parameter.

Decomposition:
- Shared package `fgen_pkg`:
  - FSM state encoding (localparams: IDLE, STEP_UP, STEP_DN, HOLD, REPEAT, LOCKED).
  - FW.
  - The 50 MHz `CLK_HZ` constant.
  - Millisecond-to-cycle constants for the debounce, hold and repeat times.
- One natural sub-module, `btn_sync_debounce`:
  - 2-flop synchroniser plus stability counter for a 2-bit vector.
  - Outputs the accepted pair.
- The FSM and the saturating arithmetic stay in `freq_step_ctrl`.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 20, REPEAT_CYCLES = 8, STEP = 1024, FW_MIN = 1024, FW_MAX = 8192, FW_DEFAULT = 4096, and a 20 ns clock.
1. Reset → `freq_word = 4096`, `freq_update = 0`, `at_min = at_max = 0`. Hold `Bt_Plus` clean for 10 cycles → exactly one pulse, `freq_word = 5120` at cycle 7 after the press.
2. `Bt_Plus` toggled every 2 cycles for 40 cycles, then released → no `freq_update`, `freq_word` stays 4096.
3. `Bt_Plus` held for 60 cycles → pulses at cycles 7, 28, 37, 46 and 55. `freq_word` reaches 8192 on the 4th step, `at_max = 1`, and the 5th step produces no pulse.
4. `Bt_Minus` held long enough for 4 steps from 4096 → values 3072, 2048, 1024, then saturated at 1024 with `at_min = 1` and no further pulses.
5. Press `Bt_Plus`, and 2 cycles later press `Bt_Minus`; hold both for 30 cycles, release `Bt_Plus`, hold `Bt_Minus` for 30 cycles, then release → LOCKED throughout, no step, `freq_word` unchanged. The next clean `Bt_Minus` press steps to 3072.
6. Assert `reset` for one cycle mid-REPEAT while `Bt_Plus` stays high → `freq_word = 4096` next cycle and no step until `Bt_Plus` is released and re-pressed.
